// File: rtl/mbrtu_pkg.sv
// Shared definitions for the Modbus RTU receive framer: state codes, CRC constants,
// frame length limits and the byte-wide CRC-16/MODBUS step.
package mbrtu_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RCV   = 3'd2,
    ST_ERROR = 3'd3,
    ST_HOLD  = 3'd4
  } mbrtu_state_e;

  localparam logic [15:0] MBRTU_CRC_POLY = 16'hA001;
  localparam logic [15:0] MBRTU_CRC_INIT = 16'hFFFF;
  localparam int          MBRTU_MIN_LEN  = 4;
  localparam int          MBRTU_MAX_LEN  = 256;

  function automatic logic [15:0] mbrtu_crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    // NOTE: blocking assignments are correct here: c is a combinational temporary, not state.
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ MBRTU_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mb_crc16.sv
// Byte-wide CRC-16/MODBUS accumulator with registered state; i_seed restarts from the
// init value and, together with i_update, folds the first byte in on the same edge.
module mb_crc16
  import mbrtu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_seed,
  input  logic        i_update,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_base;

  assign w_base = i_seed ? MBRTU_CRC_INIT : r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= MBRTU_CRC_INIT;
    end else if (i_update) begin
      r_crc <= mbrtu_crc_step(w_base, i_data);
    end else if (i_seed) begin
      r_crc <= MBRTU_CRC_INIT;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/mb_rtu_rx_framer.sv
// Modbus RTU receive framer: t1.5/t3.5 silence framing, one-frame buffer, ready/ack hand-off.
// Define MBRTU_CRC_CHECK_EN to build the CRC-16 check into outFrameOk.
module mb_rtu_rx_framer
  import mbrtu_pkg::*;
#(
  parameter int BUF_DEPTH = MBRTU_MAX_LEN,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inEnable,
  input  logic              inRxByteValid,
  input  logic [7:0]        inRxByte,
  input  logic              inRxError,
  input  logic [23:0]       inT15Ticks,
  input  logic [23:0]       inT35Ticks,
  input  logic              inFrameAck,
  input  logic [ADDR_W-1:0] inRdAddr,
  output logic [7:0]        outRdData,
  output logic              outFrameReady,
  output logic [ADDR_W:0]   outFrameLen,
  output logic              outFrameOk,
  output logic              outDropped,
  output logic [2:0]        outState
);

  localparam logic [ADDR_W:0] LP_DEPTH   = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0] LP_MIN_LEN = (ADDR_W+1)'(MBRTU_MIN_LEN);

  mbrtu_state_e    r_state;
  logic [23:0]     r_cnt;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_frame_len;
  logic            r_frame_ready;
  logic            r_frame_ok;
  logic            r_dropped;
  logic [7:0]      r_rd_data;
  logic [7:0]      r_mem [BUF_DEPTH];

  logic              w_strobe;
  logic              w_t15_ok;
  logic              w_t35_hit;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_crc_ok;

  assign w_strobe  = inRxByteValid | inRxError;
  assign w_t15_ok  = (r_cnt <= inT15Ticks);
  assign w_t35_hit = (r_cnt >= inT35Ticks);

  // A byte is stored only when it is error-free and either opens a frame or extends one in time.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    if (inEnable && inRxByteValid && !inRxError) begin
      if (r_state == ST_IDLE) begin
        w_wr_en = 1'b1;
      end else if (r_state == ST_RCV && w_t15_ok && r_len != LP_DEPTH) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_len[ADDR_W-1:0];
      end
    end
  end

`ifdef MBRTU_CRC_CHECK_EN
  logic [15:0] w_crc;

  mb_crc16 u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_seed   (w_wr_en && (r_state == ST_IDLE)),
    .i_update (w_wr_en),
    .i_data   (inRxByte),
    .o_crc    (w_crc)
  );

  // Residual over payload plus its appended CRC is zero for an intact frame.
  assign w_crc_ok = (w_crc == 16'h0000);
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_cnt         <= '0;
      r_len         <= '0;
      r_frame_len   <= '0;
      r_frame_ready <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      if (!inEnable) begin
        r_state       <= ST_INIT;
        r_cnt         <= '0;
        r_frame_ready <= 1'b0;
        r_frame_ok    <= 1'b0;
      end else begin
        // Silence counter; HOLD ignores line activity so dropped bytes do not restart it.
        if (r_state != ST_HOLD && w_strobe) begin
          r_cnt <= '0;
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + 24'd1;
        end

        case (r_state)
          ST_INIT: begin
            if (!w_strobe && w_t35_hit) r_state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (inRxError) begin
              r_state <= ST_ERROR;
            end else if (inRxByteValid) begin
              r_state <= ST_RCV;
              r_len   <= (ADDR_W+1)'(1);
            end
          end
          ST_RCV: begin
            if (inRxError) begin
              r_state <= ST_ERROR;
            end else if (inRxByteValid) begin
              if (w_wr_en) r_len <= r_len + (ADDR_W+1)'(1);
              else         r_state <= ST_ERROR;
            end else if (w_t35_hit) begin
              r_state       <= ST_HOLD;
              r_frame_ready <= 1'b1;
              r_frame_len   <= r_len;
              r_frame_ok    <= (r_len >= LP_MIN_LEN) && w_crc_ok;
            end
          end
          ST_ERROR: begin
            if (!w_strobe && w_t35_hit) r_state <= ST_IDLE;
          end
          ST_HOLD: begin
            if (inRxByteValid) r_dropped <= 1'b1;
            if (inFrameAck) begin
              r_state       <= ST_INIT;
              r_cnt         <= '0;
              r_frame_ready <= 1'b0;
              r_frame_ok    <= 1'b0;
            end
          end
          default: r_state <= ST_INIT;
        endcase
      end
    end
  end

  // NOTE: the frame buffer has no reset; its contents are only meaningful below outFrameLen.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= inRxByte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[inRdAddr];
  end

  assign outRdData     = r_rd_data;
  assign outFrameReady = r_frame_ready;
  assign outFrameLen   = r_frame_len;
  assign outFrameOk    = r_frame_ok;
  assign outDropped    = r_dropped;
  assign outState      = r_state;

endmodule

// File: tb/tb_mb_rtu_rx_framer.sv
// Self-checking bench for mb_rtu_rx_framer: frame table, hand-written corner sequences and
// randomized frames scored by a frame-level reference model.
module tb_mb_rtu_rx_framer;

  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_RCV = 3'd2, S_ERROR = 3'd3, S_HOLD = 3'd4;
`ifdef MBRTU_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;
  logic [23:0] t15;
  logic [23:0] t35;
  logic        ack;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        ready;
  logic [8:0]  flen;
  logic        ok;
  logic        dropped;
  logic [2:0]  state;

  mb_rtu_rx_framer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inEnable      (en),
    .inRxByteValid (rx_valid),
    .inRxByte      (rx_byte),
    .inRxError     (rx_err),
    .inT15Ticks    (t15),
    .inT35Ticks    (t35),
    .inFrameAck    (ack),
    .inRdAddr      (rd_addr),
    .outRdData     (rd_data),
    .outFrameReady (ready),
    .outFrameLen   (flen),
    .outFrameOk    (ok),
    .outDropped    (dropped),
    .outState      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Transmit plan: byte, spacing from previous byte strobe (clk cycles), error strobe.
  logic [7:0] tx_b[$];
  int         tx_gap[$];
  bit         tx_err[$];

  // Bit-serial CRC-16/MODBUS over the first cnt planned bytes, LSB of each byte first.
  function automatic logic [15:0] ref_crc(input int cnt);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ tx_b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    rx_err   = e;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_tx();
    for (int i = 0; i < tx_b.size(); i++) begin
      if (i > 0) idle(tx_gap[i] - 2);
      send_byte(tx_b[i], tx_err[i]);
    end
  endtask

  task automatic plan_clear();
    tx_b.delete();
    tx_gap.delete();
    tx_err.delete();
  endtask

  task automatic plan_push(input logic [7:0] b, input int gap, input bit e);
    tx_b.push_back(b);
    tx_gap.push_back(gap);
    tx_err.push_back(e);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < tx_b.size(); i++) begin
      @(negedge clk);
      rd_addr = 8'(i);
      @(negedge clk);
      check($sformatf("%s rd[%0d]", tag, i), rd_data, tx_b[i]);
    end
  endtask

  // Frame-level model: a frame survives only with no error strobe, every inter-byte
  // silence within t1.5 and at most 256 bytes; ok needs >= 4 bytes and, with CRC, zero residual.
  task automatic check_model(input string tag);
    bit good;
    int n;
    n    = tx_b.size();
    good = (n <= 256);
    for (int i = 0; i < n; i++) begin
      if (tx_err[i]) good = 1'b0;
      if (i > 0 && (tx_gap[i] - 1) > int'(t15)) good = 1'b0;
    end
    check({tag, " ready"}, ready, good);
    if (good) begin
      check({tag, " len"}, flen, n);
      check({tag, " ok"}, ok, (n >= 4) && (!CRC_EN || ref_crc(n) == 16'h0000));
      check({tag, " state"}, state, S_HOLD);
      readback(tag);
    end else begin
      check({tag, " state"}, state, S_IDLE);
    end
  endtask

  task automatic release_frame(input string tag);
    if (ready) pulse_ack();
    idle(40);
    check({tag, " back to idle"}, state, S_IDLE);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [95:0] data;
    int          gap_idx;
    int          gap_len;
    bit          exp_ready;
    int          exp_len;
    bit          exp_ok;
    logic [2:0]  exp_state;
  } vec_t;

  function automatic vec_t mk(input string name, input int n, input logic [95:0] data,
                              input int gi, input int gl, input bit er, input int el,
                              input bit eo, input logic [2:0] es);
    vec_t v;
    v.name = name; v.n = n; v.data = data; v.gap_idx = gi; v.gap_len = gl;
    v.exp_ready = er; v.exp_len = el; v.exp_ok = eo; v.exp_state = es;
    return v;
  endfunction

  localparam logic [95:0] GOOD_FRAME = 96'h0103_0000_0001_840A_0000_0000;
  localparam logic [95:0] BAD_FRAME  = 96'h0103_0000_0001_840B_0000_0000;

  vec_t vecs[7];

  initial begin
    logic [15:0] c;
    int          n;

    en = 1'b1; rx_valid = 1'b0; rx_byte = '0; rx_err = 1'b0;
    t15 = 24'd15; t35 = 24'd35; ack = 1'b0; rd_addr = '0;
    rst_n = 1'b0;

    vecs[0] = mk("good",      8, GOOD_FRAME, -1, 10, 1'b1, 8, 1'b1,    S_HOLD);
    vecs[1] = mk("bad_crc",   8, BAD_FRAME,  -1, 10, 1'b1, 8, !CRC_EN, S_HOLD);
    vecs[2] = mk("gap20",     8, GOOD_FRAME,  3, 20, 1'b0, 0, 1'b0,    S_IDLE);
    vecs[3] = mk("good_after",8, GOOD_FRAME, -1, 10, 1'b1, 8, 1'b1,    S_HOLD);
    vecs[4] = mk("short",     2, GOOD_FRAME, -1, 10, 1'b1, 2, 1'b0,    S_HOLD);
    vecs[5] = mk("gap16_edge",8, GOOD_FRAME,  5, 16, 1'b1, 8, 1'b1,    S_HOLD);
    vecs[6] = mk("gap17_edge",8, GOOD_FRAME,  5, 17, 1'b0, 0, 1'b0,    S_IDLE);

    // Reset values
    idle(3);
    check("rst ready", ready, 1'b0);
    check("rst ok", ok, 1'b0);
    check("rst dropped", dropped, 1'b0);
    check("rst rd_data", rd_data, 8'h00);
    check("rst len", flen, 9'd0);
    check("rst state", state, S_INIT);
    rst_n = 1'b1;
    idle(35);
    check("init before t35", state, S_INIT);
    idle(1);
    check("idle after t35", state, S_IDLE);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      plan_clear();
      for (int i = 0; i < vecs[v].n; i++)
        plan_push(vecs[v].data[(11-i)*8 +: 8], (i == vecs[v].gap_idx) ? vecs[v].gap_len : 10, 1'b0);
      send_tx();
      idle(36);
      check({vecs[v].name, " ready"}, ready, vecs[v].exp_ready);
      check({vecs[v].name, " state"}, state, vecs[v].exp_state);
      if (vecs[v].exp_ready) begin
        check({vecs[v].name, " len"}, flen, vecs[v].exp_len);
        check({vecs[v].name, " ok"}, ok, vecs[v].exp_ok);
        readback(vecs[v].name);
      end
      release_frame(vecs[v].name);
    end

    // Exact ready timing, then HOLD drops and ack+byte collision
    plan_clear();
    for (int i = 0; i < 8; i++) plan_push(GOOD_FRAME[(11-i)*8 +: 8], 10, 1'b0);
    send_tx();
    idle(35);
    check("t35-1 ready", ready, 1'b0);
    check("t35-1 state", state, S_RCV);
    idle(1);
    check("t35 ready", ready, 1'b1);
    check("t35 state", state, S_HOLD);
    send_byte(8'hAA, 1'b0);
    check("hold drop1", dropped, 1'b1);
    idle(1);
    check("hold drop1 end", dropped, 1'b0);
    idle(3);
    send_byte(8'h55, 1'b0);
    check("hold drop2", dropped, 1'b1);
    check("hold state", state, S_HOLD);
    check("hold len", flen, 9'd8);
    readback("hold buffer");
    @(negedge clk);
    ack = 1'b1; rx_valid = 1'b1; rx_byte = 8'h77;
    @(negedge clk);
    ack = 1'b0; rx_valid = 1'b0;
    check("ack+byte state", state, S_INIT);
    check("ack+byte dropped", dropped, 1'b1);
    check("ack+byte ready", ready, 1'b0);
    idle(35);
    check("ack init hold", state, S_INIT);
    idle(1);
    check("ack idle", state, S_IDLE);

    // Error strobe wins over byte; ack outside HOLD is ignored
    send_byte(8'h11, 1'b1);
    check("err+byte state", state, S_ERROR);
    idle(36);
    check("err recover", state, S_IDLE);
    pulse_ack();
    check("stray ack", state, S_IDLE);

    // Maximum frame (256 bytes) and overflow (257 bytes)
    plan_clear();
    for (int i = 0; i < 254; i++) plan_push(8'($urandom), 10, 1'b0);
    c = ref_crc(254);
    plan_push(c[7:0], 10, 1'b0);
    plan_push(c[15:8], 10, 1'b0);
    send_tx();
    idle(36);
    check_model("max256");
    release_frame("max256");
    plan_clear();
    for (int i = 0; i < 257; i++) plan_push(8'($urandom), 10, 1'b0);
    send_tx();
    check("overflow state", state, S_ERROR);
    idle(36);
    check_model("ovf257");
    release_frame("ovf257");

    // Enable dropped mid-RCV and in HOLD
    plan_clear();
    for (int i = 0; i < 3; i++) plan_push(8'(i + 1), 10, 1'b0);
    send_tx();
    idle(2);
    en = 1'b0;
    @(negedge clk);
    check("en low rcv state", state, S_INIT);
    check("en low rcv ready", ready, 1'b0);
    en = 1'b1;
    idle(40);
    check("en restore", state, S_IDLE);
    plan_clear();
    for (int i = 0; i < 8; i++) plan_push(GOOD_FRAME[(11-i)*8 +: 8], 10, 1'b0);
    send_tx();
    idle(36);
    check("en hold ready", ready, 1'b1);
    en = 1'b0;
    @(negedge clk);
    check("en low hold ready", ready, 1'b0);
    check("en low hold ok", ok, 1'b0);
    check("en low hold state", state, S_INIT);
    en = 1'b1;
    idle(40);

    // Asynchronous reset mid-frame
    send_byte(8'h01, 1'b0);
    idle(8);
    send_byte(8'h03, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst state", state, S_INIT);
    check("async rst len", flen, 9'd0);
    check("async rst ready", ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    check("post rst idle", state, S_IDLE);

    // Randomized frames against the frame-level model
    for (int f = 0; f < 40; f++) begin
      plan_clear();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        plan_push(8'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(15, 26) : $urandom_range(3, 14),
                  $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        c = ref_crc(n);
        plan_push(c[7:0], $urandom_range(3, 14), 1'b0);
        plan_push(c[15:8], $urandom_range(3, 14), 1'b0);
      end
      send_tx();
      idle(36);
      check_model($sformatf("rand%0d", f));
      release_frame($sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
